// File: rtl/mac_pkg.sv
// Shared helpers for the multi-lane MAC engine.
//   clog2     : ceiling log2 used for adder-tree growth bits
//   calc_pw   : per-lane product width (AW+BW)
//   calc_sw   : adder-tree sum width (PW + clog2(LANES))
//   acc_max   : largest representable accumulator value for ACCW/SIGNED
//   acc_min   : smallest representable accumulator value for ACCW/SIGNED
// The bound functions return a MAXW-wide pattern; callers cast it down
// to ACCW bits.
package mac_pkg;

  localparam int MAXW = 128;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int calc_pw(input int aw, input int bw);
    return aw + bw;
  endfunction

  function automatic int calc_sw(input int aw, input int bw, input int lanes);
    return aw + bw + clog2(lanes);
  endfunction

  function automatic logic [MAXW-1:0] acc_max(input int accw, input int sgn);
    logic [MAXW-1:0] ones;
    ones = '1;
    return ones >> (MAXW - accw + ((sgn != 0) ? 1 : 0));
  endfunction

  function automatic logic [MAXW-1:0] acc_min(input int accw, input int sgn);
    logic [MAXW-1:0] one;
    one = MAXW'(1);
    return (sgn != 0) ? (one << (accw - 1)) : '0;
  endfunction

endpackage

// File: rtl/mac_vector_unit_adder_tree.sv
// mac_adder_tree: registered reduction of LANES products into one sum.
// Ports:
//   clk    : rising-edge clock
//   i_adv  : pipeline advance; the sum register holds when low
//   i_prod : LANES packed products, lane i at [i*PW +: PW]
//   o_sum  : registered sum, PW+clog2(LANES) bits
// Products are sign- or zero-extended to the sum width before adding, so
// the sum cannot overflow. The sum is pure data and carries no reset; its
// validity travels alongside in the parent.
module mac_adder_tree
  import mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int PW     = 32,
  parameter int SIGNED = 0
) (
  input  logic                            clk,
  input  logic                            i_adv,
  input  logic [LANES*PW-1:0]             i_prod,
  output logic [PW+clog2(LANES)-1:0]      o_sum
);

  localparam int SW = PW + clog2(LANES);

  logic [SW-1:0]        w_sum;
  logic [PW-1:0]        w_p;
  logic signed [PW-1:0] w_ps;

  always_comb begin
    w_sum = '0;
    w_p   = '0;
    w_ps  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_p  = i_prod[i*PW +: PW];
      w_ps = signed'(w_p);
      if (SIGNED != 0) w_sum = w_sum + SW'(w_ps);
      else             w_sum = w_sum + SW'(w_p);
    end
  end

  // ---- stage p2: reduced sum ----
  always_ff @(posedge clk) begin
    if (i_adv) o_sum <= w_sum;
  end

endmodule

// File: rtl/mac_vector_unit.sv
// mac_vector_unit: multi-lane pipelined multiply-accumulate engine.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : global enable; low freezes every register
//   in_valid/in_ready   : input beat handshake
//   in_first/in_last    : packet framing (restart accumulator / emit result)
//   a, b                : LANES packed operands, lane i at [i*AW]/[i*BW]
//   out_valid/out_ready : result handshake
//   out_acc, out_ovf    : packet result and sticky overflow flag
// Pipeline: p1 registers lane products, p2 registers the adder-tree sum,
// p3 updates the accumulator and, on a last beat, the output register.
// The whole pipe stalls together whenever a held result blocks the output.
module mac_vector_unit
  import mac_pkg::*;
#(
  parameter int AW       = 16,
  parameter int BW       = 16,
  parameter int ACCW     = 40,
  parameter int LANES    = 4,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [LANES*AW-1:0]   a,
  input  logic [LANES*BW-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCW-1:0]       out_acc,
  output logic                  out_ovf
);

  localparam int PW = calc_pw(AW, BW);
  localparam int SW = calc_sw(AW, BW, LANES);
  localparam logic [ACCW-1:0] SAT_MAX = ACCW'(acc_max(ACCW, SIGNED));
  localparam logic [ACCW-1:0] SAT_MIN = ACCW'(acc_min(ACCW, SIGNED));

  // Returns {overflow, result} for an ACCW+1-bit raw sum. Signed overflow
  // shows as disagreement between the two top bits; unsigned operands are
  // never negative, so only the carry bit matters.
  function automatic logic [ACCW:0] sat_acc(input logic [ACCW:0] x);
    logic ovf;
    ovf = (SIGNED != 0) ? (x[ACCW] ^ x[ACCW-1]) : x[ACCW];
    if (!ovf)                          sat_acc = {1'b0, x[ACCW-1:0]};
    else if (SATURATE == 0)            sat_acc = {1'b1, x[ACCW-1:0]};
    else if (SIGNED != 0 && x[ACCW])   sat_acc = {1'b1, SAT_MIN};
    else                               sat_acc = {1'b1, SAT_MAX};
  endfunction

  logic                  w_adv;
  logic [LANES*PW-1:0]   w_prod;
  logic signed [PW-1:0]  w_sa, w_sb;
  logic [PW-1:0]         w_ua, w_ub;

  logic [LANES*PW-1:0]   r_prod_p1;
  logic                  r_vld_p1, r_first_p1, r_last_p1;
  logic [SW-1:0]         w_sum_p2;
  logic                  r_vld_p2, r_first_p2, r_last_p2;

  logic [ACCW-1:0]       r_acc;
  logic                  r_sticky;
  logic                  r_out_valid;
  logic [ACCW-1:0]       r_out_acc;
  logic                  r_out_ovf;

  logic [ACCW-1:0]       w_base;
  logic signed [ACCW-1:0] w_base_s;
  logic signed [SW-1:0]  w_sum_s;
  logic [ACCW:0]         w_base_x, w_sum_x, w_raw, w_sat;
  logic [ACCW-1:0]       w_acc_next;
  logic                  w_ovf, w_sticky_next;

  assign w_adv     = en && (!r_out_valid || out_ready);
  // Gated with rst_n so the port reads 0 throughout reset even with en=1.
  assign in_ready  = w_adv && rst_n;
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;

  // Lanes are extended to the full product width before multiplying so the
  // product is computed at PW bits, not at the operand width.
  always_comb begin
    w_prod = '0;
    w_sa   = '0;
    w_sb   = '0;
    w_ua   = '0;
    w_ub   = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sa = PW'($signed(a[i*AW +: AW]));
      w_sb = PW'($signed(b[i*BW +: BW]));
      w_ua = PW'(a[i*AW +: AW]);
      w_ub = PW'(b[i*BW +: BW]);
      if (SIGNED != 0) w_prod[i*PW +: PW] = w_sa * w_sb;
      else             w_prod[i*PW +: PW] = w_ua * w_ub;
    end
  end

  // ---- stage p1: lane products ----
  always_ff @(posedge clk) begin
    if (w_adv) r_prod_p1 <= w_prod;
  end

  // ---- stage p2: adder tree ----
  mac_adder_tree #(
    .LANES  (LANES),
    .PW     (PW),
    .SIGNED (SIGNED)
  ) u_tree (
    .clk    (clk),
    .i_adv  (w_adv),
    .i_prod (r_prod_p1),
    .o_sum  (w_sum_p2)
  );

  // ---- stage p3: accumulate at ACCW+1 bits, then saturate or wrap ----
  always_comb begin
    w_base   = r_first_p2 ? '0 : r_acc;
    w_base_s = signed'(w_base);
    w_sum_s  = signed'(w_sum_p2);
    if (SIGNED != 0) begin
      w_base_x = (ACCW+1)'(w_base_s);
      w_sum_x  = (ACCW+1)'(w_sum_s);
    end else begin
      w_base_x = (ACCW+1)'(w_base);
      w_sum_x  = (ACCW+1)'(w_sum_p2);
    end
    w_raw         = w_base_x + w_sum_x;
    w_sat         = sat_acc(w_raw);
    w_acc_next    = w_sat[ACCW-1:0];
    w_ovf         = w_sat[ACCW];
    w_sticky_next = (r_first_p2 ? 1'b0 : r_sticky) | w_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_first_p1  <= 1'b0;
      r_last_p1   <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_first_p2  <= 1'b0;
      r_last_p2   <= 1'b0;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1   <= in_valid;
      r_first_p1 <= in_first;
      r_last_p1  <= in_last;
      r_vld_p2   <= r_vld_p1;
      r_first_p2 <= r_first_p1;
      r_last_p2  <= r_last_p1;
      if (r_vld_p2) begin
        r_acc    <= w_acc_next;
        r_sticky <= w_sticky_next;
      end
      // A new result may load on the same edge the old one is consumed.
      if (r_vld_p2 && r_last_p2) begin
        r_out_valid <= 1'b1;
        r_out_acc   <= w_acc_next;
        r_out_ovf   <= w_sticky_next;
      end else if (r_out_valid) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_vector_unit.md
# mac_vector_unit

Multi-lane, pipelined multiply-accumulate engine for the AI accelerator datapath; the parametrised successor to the single-lane MAC. Each accepted beat multiplies LANES operand pairs, reduces them through an adder tree and accumulates into one ACCW-bit result. Each packet of beats is framed with first/last flags, and the result is emitted once per packet over a valid/ready output. Signed/unsigned operation and optional saturation with a sticky overflow flag are selected by parameter.

## Interface
- AW, 16, operand A lane width
- BW, 16, operand B lane width
- ACCW, 40, accumulator/result width; must be ≥ AW+BW+clog2(LANES)
- LANES, 4, parallel multiply lanes (power of two, 1..16)
- SIGNED, 0, 1 = two's-complement operands and accumulator
- SATURATE, 1, 1 = clamp on accumulator overflow; 0 = wrap modulo 2^ACCW
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  global enable; 0 freezes all state and forces in_ready=0
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_first  in  1  beat starts a packet (accumulator restarts)
- in_last  in  1  beat ends a packet (result emitted)
- a  in  LANES*AW  lane i at bits [i*AW +: AW]
- b  in  LANES*BW  lane i at bits [i*BW +: BW]
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_acc  out  ACCW  packet result
- out_ovf  out  1  overflow occurred anywhere in the packet

## Operation
- adv = en && (!out_valid || out_ready). in_ready = adv. All pipeline stages advance only when adv=1, otherwise hold (global stall).
- S1 (accept edge): register LANES products (AW+BW bits each) with valid/first/last tags. Bubbles propagate as valid=0.
- S2: the adder tree sums the products to width AW+BW+clog2(LANES), then sign-extends (SIGNED) or zero-extends to ACCW+1.
- S3: next = (first ? 0 : acc) + sum, computed at ACCW+1 bits.
  - Overflow: result outside the ACCW range (signed: [-2^(ACCW-1), 2^(ACCW-1)-1]; unsigned: [0, 2^ACCW-1]).
  - SATURATE=1: clamp to the nearest bound. SATURATE=0: truncate.
  - ovf_sticky = (first ? 0 : ovf_sticky) | overflow.
- On an S3 beat with last: out_acc ← new acc, out_ovf ← new sticky, out_valid ← 1. Beats without last produce no output.
- first && last on the same beat is a complete single-beat dot product.
- A beat without first continues the current accumulator. After reset the accumulator is 0, so a missing first is well defined.
- out_valid clears on handshake unless a new last-beat result loads on the same edge; the new result then replaces the old one with out_valid held at 1.
- en=0: no state changes. out_valid/out_acc hold and remain consumable, but out_valid does not clear.

## Timing
- Reset values: in_ready=0 while rst_n=0; out_valid=0, out_acc=0, out_ovf=0, accumulator=0, sticky=0, all stage valids=0.
- Latency: a last beat accepted at edge k produces out_valid=1 after edge k+2 when there is no stall. Each stall cycle adds 1.
- Throughput: 1 beat/cycle while out_ready=1 or out_valid=0.
- out_acc/out_ovf are stable while out_valid && !out_ready.
- Reset asserted mid-packet discards all in-flight beats and the partial sum immediately; nothing is emitted.

## Structure
- Package mac_pkg holds:
  - the clog2 constant function
  - the derived widths PW=AW+BW and SW=PW+clog2(LANES)
  - saturation bound constants as functions of ACCW/SIGNED
- Sub-module mac_adder_tree (params LANES, PW, SIGNED): registered reduction of LANES products to SW bits; implements S2.
- Multipliers, accumulator, sticky flag and output register live in mac_vector_unit.

## Test plan
- LANES=4, unsigned: a={4,3,2,1}, b={8,7,6,5} (lane3..0), first=last=1 → out_acc=70 after edge k+2, out_ovf=0.
- Three-beat packet, lane 0 only (other lanes 0): 10·2, 3·5, 100·7, first on beat 1, last on beat 3 → single result 735. A following packet restarts from 0.
- SIGNED=1: lane0 a=-3 (0xFFFD), b=5, first=last=1 → out_acc = -15 sign-extended to 40 bits. Then a=-32768, b=-32768 → +2^30.
- ACCW=34, unsigned, SATURATE=1: two beats of all lanes 0xFFFF·0xFFFF → out_acc=2^34-1, out_ovf=1. Next first-beat packet 1·1 → 1, ovf=0. With SATURATE=0 the same stimulus gives the wrapped value and ovf=1.
- Backpressure: out_ready=0 while 3 single-beat packets stream → in_ready drops to 0 after the first result. Results 70, 735, 1 delivered in order once out_ready=1. No loss or duplication.
- rst_n pulsed low after beat 2 of a 3-beat packet → all outputs 0 immediately. A new packet 2·3 gives 6.
